// File: rtl/pipe_dest_tracker_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_dest_tracker_if : decode-side inputs and EX/MEM/WB destination outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pipe_dest_tracker_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             stall;
  logic             flush;
  logic             id_ready;
  logic [REG_W-1:0] ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [REG_W-1:0] mem_rd;
  logic             mem_reg_write;
  logic [REG_W-1:0] wb_rd;
  logic             wb_reg_write;
  logic             retire_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output id_valid, id_rd, id_reg_write, id_mem_read, stall, flush,
    input  id_ready, ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write,
           wb_rd, wb_reg_write, retire_valid, stall_cnt, retire_cnt
  );

  modport slave (
    input  id_valid, id_rd, id_reg_write, id_mem_read, stall, flush,
    output id_ready, ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write,
           wb_rd, wb_reg_write, retire_valid, stall_cnt, retire_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_dest_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_dest_tracker : carries rd/reg_write/mem_read through EX, MEM and WB
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipe_dest_tracker #(
  parameter int REG_W    = 3,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  wire                 clk,
  input  wire                 rst_n,
  pipe_dest_tracker_if.slave  bus
);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic             ex_valid_d,     ex_valid_q;
  logic [REG_W-1:0] ex_rd_d,        ex_rd_q;
  logic             ex_reg_write_d, ex_reg_write_q;
  logic             ex_mem_read_d,  ex_mem_read_q;
  logic             mem_valid_d,     mem_valid_q;
  logic [REG_W-1:0] mem_rd_d,        mem_rd_q;
  logic             mem_reg_write_d, mem_reg_write_q;
  logic             wb_valid_d,     wb_valid_q;
  logic [REG_W-1:0] wb_rd_d,        wb_rd_q;
  logic             wb_reg_write_d, wb_reg_write_q;
  logic [CNT_W-1:0] stall_cnt_d,  stall_cnt_q;
  logic [CNT_W-1:0] retire_cnt_d, retire_cnt_q;
  logic             w_mask_zero;

  assign w_mask_zero = (ZERO_REG != 0) && (bus.id_rd == '0);

  always_comb begin
    // Flush beats stall beats id_valid; anything not loaded is a bubble.
    ex_valid_d     = 1'b0;
    ex_rd_d        = '0;
    ex_reg_write_d = 1'b0;
    ex_mem_read_d  = 1'b0;
    if (!bus.flush && !bus.stall && bus.id_valid) begin
      ex_valid_d     = 1'b1;
      ex_rd_d        = bus.id_rd;
      ex_reg_write_d = bus.id_reg_write & ~w_mask_zero;
      ex_mem_read_d  = bus.id_mem_read  & ~w_mask_zero;
    end

    mem_valid_d     = ex_valid_q;
    mem_rd_d        = ex_rd_q;
    mem_reg_write_d = ex_reg_write_q;
    wb_valid_d      = mem_valid_q;
    wb_rd_d         = mem_rd_q;
    wb_reg_write_d  = mem_reg_write_q;

    stall_cnt_d = stall_cnt_q;
    if (bus.stall && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    retire_cnt_d = retire_cnt_q;
    if (mem_valid_q && (retire_cnt_q != C_CNT_MAX)) begin
      retire_cnt_d = retire_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_rd_q         <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= '0;
      wb_reg_write_q  <= 1'b0;
      stall_cnt_q     <= '0;
      retire_cnt_q    <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_rd_q         <= ex_rd_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      mem_valid_q     <= mem_valid_d;
      mem_rd_q        <= mem_rd_d;
      mem_reg_write_q <= mem_reg_write_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_reg_write_q  <= wb_reg_write_d;
      stall_cnt_q     <= stall_cnt_d;
      retire_cnt_q    <= retire_cnt_d;
    end
  end

  assign bus.id_ready      = ~bus.stall;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_reg_write  = ex_reg_write_q;
  assign bus.ex_mem_read   = ex_mem_read_q;
  assign bus.mem_rd        = mem_rd_q;
  assign bus.mem_reg_write = mem_valid_q & mem_reg_write_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_reg_write  = wb_valid_q & wb_reg_write_q;
  assign bus.retire_valid  = wb_valid_q;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.retire_cnt    = retire_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_pipe_dest_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_dest_tracker : random + directed stimulus, queue-based scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pipe_dest_tracker;
  localparam int REG_W = 3;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    bit       v;
    bit [2:0] rd;
    bit       rw;
    bit       mr;
  } instr_t;

  typedef struct {
    bit       id_ready;
    bit [2:0] ex_rd;
    bit       ex_rw;
    bit       ex_mr;
    bit [2:0] mem_rd;
    bit       mem_rw;
    bit [2:0] wb_rd;
    bit       wb_rw;
    bit       ret_v;
    int       scnt;
    int       rcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_dest_tracker_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipe_dest_tracker #(.REG_W(REG_W), .ZERO_REG(1), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t   exp_q[$];
  instr_t in_ex_hist[$];   // most recent EX entry at the front
  int     stall_total, retired_total;
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b.v = 0; b.rd = 0; b.rw = 0; b.mr = 0;
    return b;
  endfunction

  function automatic void model_reset();
    in_ex_hist.delete();
    for (int i = 0; i < 3; i++) in_ex_hist.push_back(bubble());
    stall_total   = 0;
    retired_total = 0;
  endfunction

  // One clock of stimulus: drive at negedge, predict the state after the next posedge.
  task automatic cycle(input bit rn, input bit iv, input bit [2:0] rd,
                       input bit rw, input bit mr, input bit st, input bit fl);
    instr_t n;
    exp_t   e;
    @(negedge clk);
    rst_n            = rn;
    bus.id_valid     = iv;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.stall        = st;
    bus.flush        = fl;
    if (!rn) begin
      model_reset();
    end else begin
      if (st) stall_total++;
      if (in_ex_hist[1].v) retired_total++;   // instruction now in MEM lands in WB
      n = bubble();
      if (iv && !st && !fl) begin
        n.v  = 1;
        n.rd = rd;
        n.rw = (rd == 0) ? 1'b0 : rw;
        n.mr = (rd == 0) ? 1'b0 : mr;
      end
      in_ex_hist.push_front(n);
      void'(in_ex_hist.pop_back());
    end
    e.id_ready = !st;
    e.ex_rd    = in_ex_hist[0].rd;
    e.ex_rw    = in_ex_hist[0].rw;
    e.ex_mr    = in_ex_hist[0].mr;
    e.mem_rd   = in_ex_hist[1].rd;
    e.mem_rw   = in_ex_hist[1].v && in_ex_hist[1].rw;
    e.wb_rd    = in_ex_hist[2].rd;
    e.wb_rw    = in_ex_hist[2].v && in_ex_hist[2].rw;
    e.ret_v    = in_ex_hist[2].v;
    e.scnt     = (stall_total   > CMAX) ? CMAX : stall_total;
    e.rcnt     = (retired_total > CMAX) ? CMAX : retired_total;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("id_ready",      16'(bus.id_ready),      16'(e.id_ready));
      chk("ex_rd",         16'(bus.ex_rd),         16'(e.ex_rd));
      chk("ex_reg_write",  16'(bus.ex_reg_write),  16'(e.ex_rw));
      chk("ex_mem_read",   16'(bus.ex_mem_read),   16'(e.ex_mr));
      chk("mem_rd",        16'(bus.mem_rd),        16'(e.mem_rd));
      chk("mem_reg_write", 16'(bus.mem_reg_write), 16'(e.mem_rw));
      chk("wb_rd",         16'(bus.wb_rd),         16'(e.wb_rd));
      chk("wb_reg_write",  16'(bus.wb_reg_write),  16'(e.wb_rw));
      chk("retire_valid",  16'(bus.retire_valid),  16'(e.ret_v));
      chk("stall_cnt",     16'(bus.stall_cnt),     16'(e.scnt));
      chk("retire_cnt",    16'(bus.retire_cnt),    16'(e.rcnt));
    end
  end

  initial begin
    bus.id_valid = 0; bus.id_rd = 0; bus.id_reg_write = 0;
    bus.id_mem_read = 0; bus.stall = 0; bus.flush = 0;
    model_reset();

    // Reset with a valid instruction presented
    cycle(0, 1, 3'd4, 1, 1, 0, 0);
    cycle(0, 1, 3'd4, 1, 1, 0, 0);
    // Back-to-back flow
    cycle(1, 1, 3'd3, 1, 0, 0, 0);
    cycle(1, 1, 3'd5, 1, 0, 0, 0);
    cycle(1, 1, 3'd6, 1, 0, 0, 0);
    idle(3);
    // Load followed by a one-cycle stall
    cycle(1, 1, 3'd1, 1, 1, 0, 0);
    cycle(1, 1, 3'd2, 1, 0, 1, 0);
    idle(3);
    // Flush and stall together
    cycle(1, 1, 3'd2, 1, 0, 1, 1);
    idle(3);
    // Write to r0 is masked but still retires
    cycle(1, 1, 3'd0, 1, 1, 0, 0);
    idle(3);
    // Randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7),
            3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end
    // Counter saturation from a clean start, then reset mid-stream
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 3'd7, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 1, 3'd2, 1, 0, 1, 0);
    cycle(1, 1, 3'd4, 1, 0, 0, 0);
    cycle(1, 1, 3'd5, 1, 1, 0, 0);
    cycle(0, 1, 3'd6, 1, 0, 1, 0);
    idle(3);

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: pending=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
